// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes and FSM states.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PRE  = 2'b01,
        S_RUN  = 2'b10,
        S_POST = 2'b11
    } state_e;

endpackage

// File: rtl/mdu_addsub.sv
// Shared N-bit add/subtract for the iterative datapath; purely combinational.
// sub=1 computes in1 - in2 as in1 + ~in2 + 1, so cout=1 means no borrow.
module mdu_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         sub,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N-1:0] in2_eff;

    assign in2_eff     = in2 ^ {N{sub}};
    assign {cout, sum} = {1'b0, in1} + {1'b0, in2_eff} + {{N{1'b0}}, sub};

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU over one shared adder; owns HI/LO. Latency WIDTH+2 cycles.
// No backpressure: start is ignored while busy, MTHI/MTLO only honoured when idle and start is low.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    op_e                op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   opd;     // |a| for multiply, |b| for divide
    logic [WIDTH:0]     acc;     // multiply accumulator / divide remainder
    logic [WIDTH-1:0]   mlo;     // multiplier shifter / quotient shifter
    logic               neg_q;
    logic               neg_r;
    logic               div0;

    logic               is_signed;
    logic               is_mul;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     add_in1;
    logic [WIDTH:0]     add_in2;
    logic               add_sub;
    logic [WIDTH:0]     add_sum;
    logic               add_cout;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy = (state != S_IDLE);

    always_comb begin
        is_signed = op_q[0];
        is_mul    = ~op_q[1];
        // MIN negates to itself, which is then correctly read as unsigned 2^(WIDTH-1)
        a_abs     = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
        b_abs     = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
        shifted   = {acc[WIDTH-1:0], mlo[WIDTH-1]};
        add_in1   = is_mul ? acc : shifted;
        add_in2   = (is_mul && !mlo[0]) ? '0 : {1'b0, opd};
        add_sub   = ~is_mul;
        prod      = {acc[WIDTH-1:0], mlo};
        prod_fix  = neg_q ? -prod : prod;
        quo_fix   = neg_q ? -mlo : mlo;
        rem_fix   = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end

    mdu_addsub #(
        .N (WIDTH + 1)
    ) u_addsub (
        .in1  (add_in1),
        .in2  (add_in2),
        .sub  (add_sub),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            op_q  <= OP_MULTU;
            a_q   <= '0;
            b_q   <= '0;
            opd   <= '0;
            acc   <= '0;
            mlo   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            div0  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_PRE;
                        op_q  <= op_e'(op);
                        a_q   <= a;
                        b_q   <= b;
                    end else begin
                        if (wr_hi) hi <= wr_data;
                        if (wr_lo) lo <= wr_data;
                    end
                end
                S_PRE: begin
                    neg_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    neg_r <= is_signed & a_q[WIDTH-1];
                    div0  <= ~is_mul & (b_q == '0);
                    acc   <= '0;
                    cnt   <= '0;
                    if (is_mul) begin
                        opd <= a_abs;
                        mlo <= b_abs;
                    end else begin
                        opd <= b_abs;
                        mlo <= a_abs;
                    end
                    state <= S_RUN;
                end
                S_RUN: begin
                    if (is_mul) begin
                        acc <= {1'b0, add_sum[WIDTH:1]};
                        mlo <= {add_sum[0], mlo[WIDTH-1:1]};
                    end else if (add_cout) begin
                        acc <= add_sum;
                        mlo <= {mlo[WIDTH-2:0], 1'b1};
                    end else begin
                        acc <= shifted;
                        mlo <= {mlo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= S_POST;
                end
                S_POST: begin
                    state <= S_IDLE;
                    done  <= 1'b1;
                    if (is_mul) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (div0) begin
                        hi <= a_q;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: expected HI/LO queued at start, checked on done.
module tb_mdu_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         wr_hi;
    logic         wr_lo;
    logic [W-1:0] wr_data;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    logic [63:0]  exp_q[$];
    logic [W-1:0] model_hi;
    logic [W-1:0] model_lo;

    always #5 clk = ~clk;

    mdu_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0]        p;
        logic signed [31:0] sx;
        logic signed [31:0] sy;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        sx = x;
        sy = y;
        case (o)
            2'b00: p = {32'd0, x} * {32'd0, y};
            2'b01: p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
            2'b10: p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 0) p = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    p  = {sr, sq};
                end
            end
        endcase
        return p;
    endfunction

    // Called at a negedge; drives start for one cycle and returns at the following negedge.
    task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        exp_q.push_back(model(o, x, y));
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom);
    endtask

    // Waits for done (bounded), pops the scoreboard and checks HI/LO; returns in the done cycle.
    task automatic wait_done(input string name);
        logic [63:0] e;
        int n;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: done not seen after %0d cycles, required within 200", name, n);
            return;
        end
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: done pulse with empty scoreboard, required no pulse", name);
            return;
        end
        e = exp_q.pop_front();
        model_hi = e[63:32];
        model_lo = e[31:0];
        checks++;
        if (hi !== e[63:32]) begin
            errors++;
            $display("FAIL %s hi: got %h, required %h", name, hi, e[63:32]);
        end
        checks++;
        if (lo !== e[31:0]) begin
            errors++;
            $display("FAIL %s lo: got %h, required %h", name, lo, e[31:0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; op = 2'b00; a = '0; b = '0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, hi, lo} !== {2'b00, 64'd0}) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
        end
        rst_n = 1'b1;
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
    endtask

    task automatic test_multu_latency();
        int n;
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n = 0;
        while (busy && n < 100) begin
            n++;
            checks++;
            if (hi !== model_hi || done !== 1'b0) begin
                errors++;
                $display("FAIL hold during op: hi=%h done=%b, required hi=%h done=0", hi, done, model_hi);
            end
            @(negedge clk);
        end
        checks++;
        if (n != 34) begin
            errors++;
            $display("FAIL busy length: got %0d cycles, required 34", n);
        end
        wait_done("multu ffff*ffff");
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done width: done=%b one cycle later, required 0", done);
        end
    endtask

    task automatic test_signed_and_div();
        start_op(2'b01, 32'hFFFF_FFFD, 32'd5);           wait_done("mult -3*5");    @(negedge clk);
        start_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done("mult min*-1");  @(negedge clk);
        start_op(2'b11, 32'hFFFF_FFF9, 32'd2);           wait_done("div -7/2");     @(negedge clk);
        start_op(2'b10, 32'd100, 32'd7);                 wait_done("divu 100/7");   @(negedge clk);
        start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);   wait_done("div min/-1");   @(negedge clk);
        start_op(2'b10, 32'h0000_1234, 32'd0);           wait_done("divu by zero"); @(negedge clk);
        start_op(2'b11, 32'hFFFF_FF00, 32'd0);           wait_done("div by zero");  @(negedge clk);
        start_op(2'b11, 32'd7, 32'hFFFF_FFFE);           wait_done("div 7/-2");     @(negedge clk);
    endtask

    task automatic test_ignore_while_busy();
        start_op(2'b00, 32'd6, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        wr_hi = 1'b1; wr_data = 32'hAA;
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0;
        checks++;
        if (hi !== model_hi) begin
            errors++;
            $display("FAIL wr_hi while busy: hi=%h, required %h", hi, model_hi);
        end
        wait_done("ignored start/wr");
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start while busy: busy=%b after done, required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        start_op(2'b10, 32'd1000, 32'd33);
        wait_done("b2b first");
        start_op(2'b01, 32'hFFFF_FFF0, 32'hFFFF_FFF0);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b busy: busy=%b after start in done cycle, required 1", busy);
        end
        wait_done("b2b second");
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        wr_hi = 1'b1; wr_data = 32'hAA;
        @(negedge clk);
        wr_hi = 1'b0;
        model_hi = 32'hAA;
        checks++;
        if (hi !== 32'hAA) begin
            errors++;
            $display("FAIL mthi: hi=%h, required 000000aa", hi);
        end
        wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'h1357;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b0;
        model_hi = 32'h1357; model_lo = 32'h1357;
        checks++;
        if (hi !== 32'h1357 || lo !== 32'h1357) begin
            errors++;
            $display("FAIL mthi+mtlo: hi=%h lo=%h, required both 00001357", hi, lo);
        end
        wr_lo = 1'b1; wr_data = 32'h55;
        start_op(2'b00, 32'd2, 32'd3);
        wr_lo = 1'b0;
        checks++;
        if (lo !== model_lo) begin
            errors++;
            $display("FAIL start+wr_lo: lo=%h, required %h", lo, model_lo);
        end
        wait_done("after start+wr_lo");
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, hi, lo} !== {2'b00, 64'd0}) begin
            errors++;
            $display("FAIL async reset: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
        end
        void'(exp_q.pop_back());
        model_hi = '0; model_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(2'b00, 32'd6, 32'd7);
        wait_done("multu 6*7 after reset");
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] vals[6];
        logic [31:0] x;
        logic [31:0] y;
        vals = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h3};
        for (int i = 0; i < 16; i++) begin
            x = ($urandom_range(0, 3) == 0) ? vals[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? vals[$urandom_range(0, 5)] : $urandom >> $urandom_range(0, 28);
            start_op(2'($urandom), x, y);
            wait_done("random op");
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_multu_latency();
        test_signed_and_div();
        test_ignore_while_busy();
        test_back_to_back();
        test_mthi_mtlo();
        test_async_reset();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
